debounce_sync: RTL

//  Input conditioning stage feeding the data input of the reset-able D flip-flop.
//  Raw asynchronous input (push-button/switch) -> N-stage synchronizer -> counter-based stability filter.

---
 rtl/debounce_sync.sv | 129 ++++++++++++
 1 files changed

// File: rtl/debounce_sync.sv
// Input conditioning: synchronizer chain followed by a counter-qualified
// level filter with registered level, complement and edge pulses.
module debounce_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 1000,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic dout_n,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   dout_n_q, dout_n_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
                dout_d  = 1'b0;
            end
        endcase
        // busy and dout_n come from next-state values so they share the same edge
        busy_d   = (state_d == WAIT_HI) || (state_d == WAIT_LO);
        dout_n_d = ~dout_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q   <= '0;
            state_q  <= IDLE_LO;
            cnt_q    <= '0;
            dout_q   <= 1'b0;
            dout_n_q <= 1'b1;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            dout_n_q <= dout_n_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
        end
    end

    assign dout   = dout_q;
    assign dout_n = dout_n_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign busy   = busy_q;

endmodule
